hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit.sv | 125 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Shadow-pipeline hazard unit for a 5-stage core: tracks EX/MEM/WB destination
// info to drive operand-forward selects and a one-cycle load-use stall.
module hazard_forward_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        flush,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        Stall,
  output logic [15:0] stall_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } ex_entry_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } mem_entry_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } wb_entry_t;

  ex_entry_t  ex_q;
  mem_entry_t mem_q;
  wb_entry_t  wb_q;

  logic mem_prod;
  logic wb_prod;

  // Shadow pipeline; a stall or flush injects an all-zero bubble into EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      wb_q.valid      <= mem_q.valid;
      wb_q.rd         <= mem_q.rd;
      wb_q.reg_write  <= mem_q.reg_write;
      mem_q.valid     <= ex_q.valid;
      mem_q.rd        <= ex_q.rd;
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.mem_read  <= ex_q.mem_read;
      if (Stall || flush) begin
        ex_q <= '0;
      end else begin
        ex_q.valid     <= id_valid;
        ex_q.rs1       <= id_rs1;
        ex_q.rs2       <= id_rs2;
        ex_q.use_rs1   <= id_use_rs1;
        ex_q.use_rs2   <= id_use_rs2;
        ex_q.rd        <= id_rd;
        ex_q.reg_write <= id_RegWrite;
        ex_q.mem_read  <= id_MemRead;
      end
      if (Stall && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  // Only real writers of a non-zero register can source a forward
  always_comb begin
    mem_prod = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0);
    wb_prod  = wb_q.valid && wb_q.reg_write && (wb_q.rd != '0);
  end

  // MEM beats WB since it carries the newer value; loads in MEM never forward
  always_comb begin
    ForwardA = SEL_RF;
    ForwardB = SEL_RF;
    if (ex_q.use_rs1 && mem_prod && !mem_q.mem_read && (mem_q.rd == ex_q.rs1)) begin
      ForwardA = SEL_MEM;
    end else if (ex_q.use_rs1 && wb_prod && (wb_q.rd == ex_q.rs1)) begin
      ForwardA = SEL_WB;
    end
    if (ex_q.use_rs2 && mem_prod && !mem_q.mem_read && (mem_q.rd == ex_q.rs2)) begin
      ForwardB = SEL_MEM;
    end else if (ex_q.use_rs2 && wb_prod && (wb_q.rd == ex_q.rs2)) begin
      ForwardB = SEL_WB;
    end
  end

  // Load in EX feeding the instruction in ID; flush suppresses the stall
  always_comb begin
    Stall = 1'b0;
    if (id_valid && !flush && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)) begin
      Stall = (id_use_rs1 && (id_rs1 == ex_q.rd)) ||
              (id_use_rs2 && (id_rs2 == ex_q.rd));
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit: forwarding, load-use stall,
// flush, x0, saturation and reset behaviour.
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic        flush;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        Stall;
  logic [15:0] stall_count;

  int n_cmp;
  int n_err;

  hazard_forward_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_RegWrite (id_RegWrite),
    .id_MemRead  (id_MemRead),
    .flush       (flush),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .Stall       (Stall),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_RegWrite = rw; id_MemRead = mr;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    repeat (2) tick();
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL reset_fa got %b want 00", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b00) begin n_err++; $display("FAIL reset_fb got %b want 00", ForwardB); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", Stall); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %h want 0000", stall_count); end
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_alu_chain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got %b want 0", Stall); end
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b10) begin n_err++; $display("FAIL alu_fa got %b want 10", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b10) begin n_err++; $display("FAIL alu_fb got %b want 10", ForwardB); end
    drain();
  endtask

  task automatic test_distance2();
    drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardB !== 2'b01) begin n_err++; $display("FAIL dist2_fb got %b want 01", ForwardB); end
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL dist2_fa got %b want 00", ForwardA); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL lu_stall1 got %b want 1", Stall); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL lu_cnt0 got %h want 0000", stall_count); end
    tick();
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL lu_stall2 got %b want 0", Stall); end
    n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_cnt1 got %h want 0001", stall_count); end
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b01) begin n_err++; $display("FAIL lu_fa got %b want 01", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b00) begin n_err++; $display("FAIL lu_fb got %b want 00", ForwardB); end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1);
    #1;
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall_a got %b want 1", Stall); end
    tick();
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL b2b_release_a got %b want 0", Stall); end
    tick();
    drive(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    #1;
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall_b got %b want 1", Stall); end
    n_cmp++; if (ForwardA !== 2'b01) begin n_err++; $display("FAIL b2b_lw_fa got %b want 01", ForwardA); end
    tick();
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL b2b_release_b got %b want 0", Stall); end
    n_cmp++; if (stall_count !== 16'd3) begin n_err++; $display("FAIL b2b_cnt got %h want 0003", stall_count); end
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b01) begin n_err++; $display("FAIL b2b_fa got %b want 01", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b01) begin n_err++; $display("FAIL b2b_fb got %b want 01", ForwardB); end
    drain();
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL x0_fa got %b want 00", ForwardA); end
    drain();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    #1;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL x0_load_stall got %b want 0", Stall); end
    drain();
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b10) begin n_err++; $display("FAIL prio_fa got %b want 10", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b10) begin n_err++; $display("FAIL prio_fb got %b want 10", ForwardB); end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b want 0", Stall); end
    tick();
    flush = 1'b0;
    drive(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd20, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL flush_bubble_fa got %b want 00", ForwardA); end
    n_cmp++; if (stall_count !== 16'd3) begin n_err++; $display("FAIL flush_cnt got %h want 0003", stall_count); end
    drain();
  endtask

  task automatic test_saturation();
    force dut.stall_count = 16'hFFFE;
    #1;
    release dut.stall_count;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      #1;
      n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL sat_stall%0d got %b want 1", i, Stall); end
      tick();
      n_cmp++; if (stall_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt%0d got %h want ffff", i, stall_count); end
      drain();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b10) begin n_err++; $display("FAIL mid_pre_fa got %b want 10", ForwardA); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL mid_rst_fa got %b want 00", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b00) begin n_err++; $display("FAIL mid_rst_fb got %b want 00", ForwardB); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got %h want 0000", stall_count); end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL mid_post_fa got %b want 00", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b00) begin n_err++; $display("FAIL mid_post_fb got %b want 00", ForwardB); end
    drain();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_alu_chain();
    test_distance2();
    test_load_use();
    test_back_to_back();
    test_x0();
    test_priority();
    test_flush();
    test_saturation();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
